// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - N-master to 1-slave sram-like bus arbiter with in-order response routing
//
// Purpose:
//   Arbitrates address phases of NUM_MASTERS sram-like request ports onto one slave port.
//   Each accepted request's master ID is queued in an order FIFO, so responses (s_data_ok/s_rdata)
//   are steered back to the issuing master in order. Up to MAX_OUTSTANDING requests may be in flight.
// Configuration macro:
//   ARB_FIXED_PRIO_EN - when defined, fixed priority (master 0 highest) replaces round-robin.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   m_req/m_wr/m_size/m_wstrb/m_addr/m_wdata   packed per-master request payloads (master i at slice i)
//   m_addr_ok, m_data_ok                one-hot (or zero) address accept / response strobes
//   m_rdata                             read data broadcast, valid with m_data_ok
//   s_req/s_wr/s_size/s_wstrb/s_addr/s_wdata   slave request payload from the granted master
//   s_addr_ok, s_data_ok, s_rdata       slave handshake and read data
//   resp_err                            sticky: response seen with no request outstanding
module sram_like_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WD         = 32,
  parameter int DATA_WD         = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MASTERS-1:0]           m_req,
  input  logic [NUM_MASTERS-1:0]           m_wr,
  input  logic [2*NUM_MASTERS-1:0]         m_size,
  input  logic [NUM_MASTERS*DATA_WD/8-1:0] m_wstrb,
  input  logic [NUM_MASTERS*ADDR_WD-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_WD-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]           m_addr_ok,
  output logic [NUM_MASTERS-1:0]           m_data_ok,
  output logic [DATA_WD-1:0]               m_rdata,
  output logic                             s_req,
  output logic                             s_wr,
  output logic [1:0]                       s_size,
  output logic [DATA_WD/8-1:0]             s_wstrb,
  output logic [ADDR_WD-1:0]               s_addr,
  output logic [DATA_WD-1:0]               s_wdata,
  input  logic                             s_addr_ok,
  input  logic                             s_data_ok,
  input  logic [DATA_WD-1:0]               s_rdata,
  output logic                             resp_err
);

  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int SW  = DATA_WD / 8;
  localparam logic [PW:0]    CNT_ONE  = 1;
  localparam logic [PW:0]    CNT_FULL = MAX_OUTSTANDING;
  localparam logic [PW-1:0]  PTR_ONE  = 1;
  localparam logic [IDW-1:0] ID_ONE   = 1;
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_MASTERS - 1);

  logic [IDW-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;
  logic           r_lock;
  logic [IDW-1:0] r_lock_id;
  logic           r_resp_err;

  logic [IDW-1:0] w_base;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_search_id;
  logic           w_search_vld;
  logic [IDW-1:0] w_grant;
  logic           w_grant_vld;
  logic           w_full;
  logic           w_empty;
  logic           w_accept;
  logic           w_pop;
  logic [IDW-1:0] w_head;

`ifdef ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IDW-1:0] r_rr_ptr;
  assign w_base = r_rr_ptr;
`endif

  // First requester at or after w_base, wrapping around the master list.
  always_comb begin
    w_search_vld = 1'b0;
    w_search_id  = '0;
    w_idx        = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_idx = IDW'((int'(w_base) + k) % NUM_MASTERS);
      if (!w_search_vld && m_req[w_idx]) begin
        w_search_vld = 1'b1;
        w_search_id  = w_idx;
      end
    end
  end

  // A pending unaccepted request pins the grant so the slave never sees the payload switch.
  assign w_grant     = r_lock ? r_lock_id : w_search_id;
  assign w_grant_vld = r_lock | w_search_vld;

  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_fifo[r_rd_ptr];

  // Full blocks s_req even if a pop happens this cycle: keeps s_data_ok off the request path.
  assign s_req    = ~reset & (|m_req) & ~w_full;
  assign w_accept = s_req & s_addr_ok;
  assign w_pop    = ~reset & s_data_ok & ~w_empty;

  assign m_rdata  = reset ? '0 : s_rdata;
  assign resp_err = r_resp_err & ~reset;

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    s_wr      = 1'b0;
    s_size    = '0;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    if (w_accept) begin
      m_addr_ok[w_grant] = 1'b1;
    end
    if (w_pop) begin
      m_data_ok[w_head] = 1'b1;
    end
    if (!reset && w_grant_vld) begin
      s_wr    = m_wr[w_grant];
      s_size  = m_size[w_grant*2 +: 2];
      s_wstrb = m_wstrb[w_grant*SW +: SW];
      s_addr  = m_addr[w_grant*ADDR_WD +: ADDR_WD];
      s_wdata = m_wdata[w_grant*DATA_WD +: DATA_WD];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lock     <= 1'b0;
      r_lock_id  <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wr_ptr] <= w_grant;
        r_wr_ptr         <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_accept) begin
        r_lock <= 1'b0;
      end else if (s_req) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end
      if (s_data_ok && w_empty) begin
        r_resp_err <= 1'b1;
      end
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_grant == ID_LAST) ? '0 : w_grant + ID_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam logic [31:0] A0 = 32'h1fc00000;
  localparam logic [31:0] A1 = 32'h80001000;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      m_req, m_wr, m_addr_ok, m_data_ok;
  logic [2*N-1:0]    m_size;
  logic [N*DW/8-1:0] m_wstrb;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [DW-1:0]     m_rdata, s_wdata, s_rdata;
  logic              s_req, s_wr, s_addr_ok, s_data_ok, resp_err;
  logic [1:0]        s_size;
  logic [DW/8-1:0]   s_wstrb;
  logic [AW-1:0]     s_addr;

  int checks = 0;
  int errors = 0;

  sram_like_arbiter #(.NUM_MASTERS(N), .ADDR_WD(AW), .DATA_WD(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .s_rdata(s_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-flight master IDs as a queue, pointer/lock as plain integers.
  int q[$];
  int rr_m = 0;
  bit lk = 1'b0;
  int lk_id = 0;
  bit err_m = 1'b0;

  always @(negedge clk) begin
    int g;
    bit gv;
    bit sreq;
    bit acc;
    bit popq;
    int base;
    logic [1:0] e_aok, e_dok;
    if (reset) begin
      chk("rst_outputs", {m_addr_ok, m_data_ok, s_req, s_wr, s_size, s_wstrb, resp_err}, '0);
      chk("rst_data", {s_addr, s_wdata}, '0);
      chk("rst_rdata", m_rdata, '0);
      q.delete();
      rr_m = 0; lk = 1'b0; lk_id = 0; err_m = 1'b0;
    end else begin
`ifdef ARB_FIXED_PRIO_EN
      base = 0;
`else
      base = rr_m;
`endif
      gv = 1'b0; g = 0;
      if (lk) begin
        gv = 1'b1; g = lk_id;
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (base + k) % N;
          if (!gv && m_req[idx]) begin gv = 1'b1; g = idx; end
        end
      end
      sreq  = (m_req != 0) && (q.size() < MO);
      acc   = sreq && s_addr_ok;
      popq  = s_data_ok && (q.size() > 0);
      e_aok = acc ? (2'b01 << g) : 2'b00;
      e_dok = popq ? (2'b01 << q[0]) : 2'b00;
      chk("m_s_req", s_req, sreq);
      chk("m_addr_ok", m_addr_ok, e_aok);
      chk("m_data_ok", m_data_ok, e_dok);
      chk("m_rdata", m_rdata, s_rdata);
      chk("m_resp_err", resp_err, err_m);
      chk("m_s_addr", s_addr, gv ? m_addr[g*AW +: AW] : '0);
      chk("m_s_wdata", s_wdata, gv ? m_wdata[g*DW +: DW] : '0);
      chk("m_s_ctl", {s_wr, s_size, s_wstrb},
          gv ? {m_wr[g], m_size[g*2 +: 2], m_wstrb[g*4 +: 4]} : '0);
      if (s_data_ok) begin
        if (popq) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (acc) begin
        q.push_back(g); rr_m = (g + 1) % N; lk = 1'b0;
      end else if (sreq) begin
        lk = 1'b1; lk_id = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    step(); idle(); reset = 1'b1;
    step(); step(); reset = 1'b0;
  endtask

  logic [7:0] rr_seq;
  logic [1:0] lk_next, drain0;

  initial begin
    reset = 1'b1; idle();
    m_wr = 2'b10; m_size = 4'b10_01; m_wstrb = 8'hf3;
    m_addr = {A1, A0}; m_wdata = {32'hdeadbeef, 32'h12345678};
`ifdef ARB_FIXED_PRIO_EN
    rr_seq = 8'b01_01_01_01; lk_next = 2'b01; drain0 = 2'b01;
`else
    rr_seq = 8'b10_01_10_01; lk_next = 2'b10; drain0 = 2'b10;
`endif
    // request during reset must be invisible
    step(); m_req = 2'b01; s_addr_ok = 1'b1; #2;
    chk("rst_s_req", s_req, 1'b0);
    chk("rst_addr_ok", m_addr_ok, 2'b00);

    // single read
    do_reset();
    step(); m_req = 2'b01; s_addr_ok = 1'b1; #2;
    chk("t1_s_req", s_req, 1'b1);
    chk("t1_s_addr", s_addr, A0);
    chk("t1_addr_ok", m_addr_ok, 2'b01);
    step(); idle(); #2;
    chk("t1_idle_req", s_req, 1'b0);
    step(); s_data_ok = 1'b1; s_rdata = 32'h3c1a0000; #2;
    chk("t1_data_ok", m_data_ok, 2'b01);
    chk("t1_rdata", m_rdata, 32'h3c1a0000);
    step(); idle(); #2;
    chk("t1_no_err", resp_err, 1'b0);

    // alternating grants, then full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(); m_req = 2'b11; s_addr_ok = 1'b1; #2;
      chk($sformatf("t2_grant%0d", i), m_addr_ok, rr_seq[2*i +: 2]);
    end
    step(); #2;
    chk("t4_model_depth", q.size(), 4);
    chk("t4_full_req", s_req, 1'b0);
    chk("t4_full_aok", m_addr_ok, 2'b00);
    step(); s_data_ok = 1'b1; s_rdata = 32'h0badf00d; #2;
    chk("t4_pop_req", s_req, 1'b0);
    chk("t4_pop_dok", m_data_ok, 2'b01);
    step(); s_data_ok = 1'b0; #2;
    chk("t4_reassert", s_req, 1'b1);
    chk("t4_reaccept", m_addr_ok, 2'b01);
    step(); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; #2;
    chk("t4_drain0", m_data_ok, drain0);
    for (int i = 0; i < 3; i++) step();
    step(); idle();

    // lock holds master 0 even once master 1 (next in rotation) requests
    do_reset();
    step(); m_req = 2'b01; s_addr_ok = 1'b1; #2;
    chk("t3_first", m_addr_ok, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step(); m_req = 2'b01; s_addr_ok = 1'b0; #2;
      chk($sformatf("t3_hold%0d", i), s_addr, A0);
    end
    step(); m_req = 2'b11; #2;
    chk("t3_locked_addr", s_addr, A0);
    chk("t3_locked_aok", m_addr_ok, 2'b00);
    step(); s_addr_ok = 1'b1; #2;
    chk("t3_accept", m_addr_ok, 2'b01);
    step(); #2;
    chk("t3_next", m_addr_ok, lk_next);

    // response ordering
    do_reset();
    step(); m_req = 2'b10; s_addr_ok = 1'b1; #2; chk("t5_a0", m_addr_ok, 2'b10);
    step(); m_req = 2'b01; #2; chk("t5_a1", m_addr_ok, 2'b01);
    step(); m_req = 2'b10; #2; chk("t5_a2", m_addr_ok, 2'b10);
    step(); idle(); s_data_ok = 1'b1; #2;
    chk("t5_model_head", q[0], 1);
    chk("t5_d0", m_data_ok, 2'b10);
    step(); #2; chk("t5_d1", m_data_ok, 2'b01);
    step(); #2; chk("t5_d2", m_data_ok, 2'b10);
    step(); idle(); #2;
    chk("t5_no_err", resp_err, 1'b0);

    // spurious response
    do_reset();
    step(); s_data_ok = 1'b1; s_rdata = 32'h55aa55aa; #2;
    chk("t6_no_dok", m_data_ok, 2'b00);
    chk("t6_err_pre", resp_err, 1'b0);
    step(); idle(); #2;
    chk("t6_err_set", resp_err, 1'b1);
    step(); step(); m_req = 2'b01; s_addr_ok = 1'b1; #2;
    chk("t6_err_sticky", resp_err, 1'b1);
    step(); idle(); reset = 1'b1; #2;
    chk("t6_err_rst", resp_err, 1'b0);
    step(); reset = 1'b0;

    // mixed traffic checked by the model every cycle
    for (int i = 0; i < 200; i++) begin
      step();
      m_req     = N'($urandom_range(0, 3));
      if (lk) m_req[lk_id] = 1'b1;
      m_wr      = N'($urandom);
      m_size    = 4'($urandom);
      m_wstrb   = 8'($urandom);
      m_addr    = {$urandom, $urandom};
      m_wdata   = {$urandom, $urandom};
      s_addr_ok = 1'($urandom);
      s_data_ok = 1'($urandom) && (q.size() > 0);
      s_rdata   = $urandom;
    end
    step(); idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
